channel_accumulator_bank: RTL and testbench

Register bank that sits directly downstream of the commit stage. It holds the 16 DSP channel registers and the double-width MAC accumulator, and applies the single in-order write stream (channel write, accumulator load, accumulator add) produced each cycle by commit. It serves registered, write-forwarded operand reads to the instruction branches. On every sample tick it captures the output channel and a saturation flag for the output path.

---
 rtl/bank_pkg.sv | 41 ++++
 rtl/channel_accumulator_bank_sat_accumulator.sv | 50 +++++
 rtl/channel_accumulator_bank.sv | 107 ++++++++++
 tb/tb_channel_accumulator_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_pkg.sv
// Shared definitions for the channel accumulator bank.
// Contents:
//   ADDR_WIDTH      channel address width (fixed at 4 bits)
//   DATA_WIDTH      channel / sample width
//   ACC_WIDTH       accumulator width (twice the channel width)
//   ACC_MAX/ACC_MIN signed accumulator clamp limits
//   sat_add         signed saturating add, returns the sum and a clamp flag
package bank_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [ACC_WIDTH-1:0] sum;
    logic                 saturated;
  } sat_result_t;

  // The add is done one bit wider than the operands; overflow shows up as
  // disagreement between the two top bits, and the extra top bit then gives
  // the true sign of the result, which selects the clamp direction.
  function automatic sat_result_t sat_add(input logic [ACC_WIDTH-1:0] a,
                                          input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] wide;
    sat_result_t        result;
    wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    result.saturated = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    if (!result.saturated) begin
      result.sum = wide[ACC_WIDTH-1:0];
    end else if (wide[ACC_WIDTH]) begin
      result.sum = ACC_MIN;
    end else begin
      result.sum = ACC_MAX;
    end
    return result;
  endfunction

endpackage

// File: rtl/channel_accumulator_bank_sat_accumulator.sv
// Saturating MAC accumulator with a per-frame sticky saturation flag.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enable              global enable; when low nothing changes
//   write_enable        accumulator write strobe
//   add_enable          1 = saturating add, 0 = load
//   write_val           accumulator operand
//   frame_clear         closes the frame: clears the sticky flag
//   acc                 accumulator register
//   sticky              set by any clamped add since the last frame_clear
module sat_accumulator
  import bank_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 write_enable,
  input  logic                 add_enable,
  input  logic [ACC_WIDTH-1:0] write_val,
  input  logic                 frame_clear,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 sticky
);

  sat_result_t add_result;
  logic        add_applied;

  // The sum is always computed; it is only committed on an enabled add.
  assign add_result  = sat_add(acc, write_val);
  assign add_applied = enable && write_enable && add_enable;

  // Load/add mux plus the sticky flag. A clamp in the same cycle as the frame
  // clear belongs to the next frame, so the set wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else begin
      if (enable && write_enable) begin
        acc <= add_enable ? add_result.sum : write_val;
      end
      if (add_applied && add_result.saturated) begin
        sticky <= 1'b1;
      end else if (frame_clear) begin
        sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/channel_accumulator_bank.sv
// Channel register bank with MAC accumulator, downstream of commit.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   enable                     gates all writes and tick captures
//   sample_tick                frame marker, captures the output channel
//   channel_write_*            channel write port (addr, data, strobe)
//   accumulator_write_*        accumulator operand and strobe
//   accumulator_add_enable     1 = add, 0 = load
//   read_addr / read_val       registered, write-forwarded operand reads
//   accumulator_out            accumulator register
//   sample_out(_valid)         captured output sample and its 1-cycle pulse
//   sample_saturated           any clamped add during the frame just closed
module channel_accumulator_bank
  import bank_pkg::*;
#(
  parameter int data_width     = DATA_WIDTH,
  parameter int n_channels     = 16,
  parameter int n_read_ports   = 2,
  parameter int output_channel = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sample_tick,
  input  logic [ADDR_WIDTH-1:0]   channel_write_addr,
  input  logic [data_width-1:0]   channel_write_val,
  input  logic                    channel_write_enable,
  input  logic [2*data_width-1:0] accumulator_write_val,
  input  logic                    accumulator_write_enable,
  input  logic                    accumulator_add_enable,
  input  logic [ADDR_WIDTH-1:0]   read_addr [n_read_ports],
  output logic [data_width-1:0]   read_val [n_read_ports],
  output logic [2*data_width-1:0] accumulator_out,
  output logic [data_width-1:0]   sample_out,
  output logic                    sample_out_valid,
  output logic                    sample_saturated
);

  logic [data_width-1:0] channel [n_channels];
  logic                  channel_write_hit;
  logic                  tick_hit;
  logic                  sticky;

  assign channel_write_hit = enable && channel_write_enable &&
                             (int'(channel_write_addr) < n_channels);
  assign tick_hit          = enable && sample_tick;

  sat_accumulator u_sat_accumulator (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .write_enable (accumulator_write_enable),
    .add_enable   (accumulator_add_enable),
    .write_val    (accumulator_write_val),
    .frame_clear  (tick_hit),
    .acc          (accumulator_out),
    .sticky       (sticky)
  );

  // Channel array; out-of-range write addresses are simply dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < n_channels; i++) begin
        channel[i] <= '0;
      end
    end else if (channel_write_hit) begin
      channel[channel_write_addr] <= channel_write_val;
    end
  end

  // Read ports run even when disabled. A same-cycle write to the addressed
  // channel is forwarded so the reader never sees the stale value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < n_read_ports; p++) begin
        read_val[p] <= '0;
      end
    end else begin
      for (int p = 0; p < n_read_ports; p++) begin
        if (channel_write_hit && (read_addr[p] == channel_write_addr)) begin
          read_val[p] <= channel_write_val;
        end else if (int'(read_addr[p]) < n_channels) begin
          read_val[p] <= channel[read_addr[p]];
        end else begin
          read_val[p] <= '0;
        end
      end
    end
  end

  // Tick capture uses the pre-write channel value and the pre-clear sticky
  // flag, so each frame reports exactly what happened inside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      sample_saturated <= 1'b0;
    end else begin
      sample_out_valid <= tick_hit;
      if (tick_hit) begin
        sample_out       <= channel[output_channel];
        sample_saturated <= sticky;
      end
    end
  end

endmodule

// File: tb/tb_channel_accumulator_bank.sv
// Self-checking bench for channel_accumulator_bank: directed cases followed by
// randomized traffic, compared against a behavioural model of the bank.
module tb_channel_accumulator_bank;

  localparam longint ACC_HI = (longint'(1) <<< 31) - 1;
  localparam longint ACC_LO = -(longint'(1) <<< 31);

  logic        clk;
  logic        reset;
  logic        enable;
  logic        sample_tick;
  logic [3:0]  channel_write_addr;
  logic [15:0] channel_write_val;
  logic        channel_write_enable;
  logic [31:0] accumulator_write_val;
  logic        accumulator_write_enable;
  logic        accumulator_add_enable;
  logic [3:0]  read_addr [2];
  logic [15:0] read_val [2];
  logic [31:0] accumulator_out;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        sample_saturated;

  // Behavioural model: the values the bank's registers should hold.
  logic [15:0] m_ch [16];
  logic [31:0] m_acc;
  logic        m_sticky;
  logic [15:0] m_read [2];
  logic [15:0] m_sample;
  logic        m_valid;
  logic        m_sat;

  int check_count = 0;
  int pass_count  = 0;

  channel_accumulator_bank dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .sample_tick              (sample_tick),
    .channel_write_addr       (channel_write_addr),
    .channel_write_val        (channel_write_val),
    .channel_write_enable     (channel_write_enable),
    .accumulator_write_val    (accumulator_write_val),
    .accumulator_write_enable (accumulator_write_enable),
    .accumulator_add_enable   (accumulator_add_enable),
    .read_addr                (read_addr),
    .read_val                 (read_val),
    .accumulator_out          (accumulator_out),
    .sample_out               (sample_out),
    .sample_out_valid         (sample_out_valid),
    .sample_saturated         (sample_saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ch[i] = '0;
    m_acc    = '0;
    m_sticky = 1'b0;
    m_read[0] = '0;
    m_read[1] = '0;
    m_sample = '0;
    m_valid  = 1'b0;
    m_sat    = 1'b0;
  endtask

  task automatic set_idle();
    enable                   = 1'b1;
    sample_tick              = 1'b0;
    channel_write_addr       = '0;
    channel_write_val        = '0;
    channel_write_enable     = 1'b0;
    accumulator_write_val    = '0;
    accumulator_write_enable = 1'b0;
    accumulator_add_enable   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_output({tag, ".read0"}, 64'(read_val[0]), 64'(m_read[0]));
    check_output({tag, ".read1"}, 64'(read_val[1]), 64'(m_read[1]));
    check_output({tag, ".acc"}, 64'(accumulator_out), 64'(m_acc));
    check_output({tag, ".sample"}, 64'(sample_out), 64'(m_sample));
    check_output({tag, ".valid"}, 64'(sample_out_valid), 64'(m_valid));
    check_output({tag, ".sat"}, 64'(sample_saturated), 64'(m_sat));
  endtask

  // Predict the effect of the currently driven inputs, clock once, then
  // compare every output one time unit after the edge.
  task automatic apply_stimulus(input string tag);
    longint sum;
    logic   clamped;
    logic   tick;
    tick    = enable && sample_tick;
    clamped = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (enable && channel_write_enable && read_addr[p] == channel_write_addr)
        m_read[p] = channel_write_val;
      else
        m_read[p] = m_ch[read_addr[p]];
    end
    m_valid = tick;
    if (tick) begin
      m_sample = m_ch[1];
      m_sat    = m_sticky;
    end
    if (enable && accumulator_write_enable) begin
      if (accumulator_add_enable) begin
        sum = longint'($signed(m_acc)) + longint'($signed(accumulator_write_val));
        if (sum > ACC_HI) begin
          sum = ACC_HI;
          clamped = 1'b1;
        end else if (sum < ACC_LO) begin
          sum = ACC_LO;
          clamped = 1'b1;
        end
        m_acc = sum[31:0];
      end else begin
        m_acc = accumulator_write_val;
      end
    end
    if (clamped) m_sticky = 1'b1;
    else if (tick) m_sticky = 1'b0;
    if (enable && channel_write_enable) m_ch[channel_write_addr] = channel_write_val;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic acc_op(input logic add, input logic [31:0] val);
    accumulator_write_enable = 1'b1;
    accumulator_add_enable   = add;
    accumulator_write_val    = val;
  endtask

  initial begin
    reset = 1'b0;
    read_addr[0] = '0;
    read_addr[1] = '0;
    set_idle();
    model_reset();
    #12;
    check_all("in_reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Every channel reads zero after reset, and no valid pulse appears.
    for (int i = 0; i < 16; i++) begin
      read_addr[0] = 4'(i);
      read_addr[1] = 4'(15 - i);
      apply_stimulus("reset_read");
    end

    // Same-cycle write is forwarded, then seen from the array.
    set_idle();
    channel_write_addr = 4'd3; channel_write_val = 16'h1234; channel_write_enable = 1'b1;
    read_addr[0] = 4'd3;
    apply_stimulus("fwd");
    check_output("fwd_const", 64'(read_val[0]), 64'h1234);
    set_idle();
    apply_stimulus("fwd_next");
    check_output("fwd_next_const", 64'(read_val[0]), 64'h1234);

    // Plain load/add, no saturation in this frame.
    acc_op(1'b0, 32'h0000_0100); apply_stimulus("load");
    acc_op(1'b1, 32'h0000_0050); apply_stimulus("add");
    check_output("add_const", 64'(accumulator_out), 64'h150);
    set_idle(); sample_tick = 1'b1; apply_stimulus("tick_nosat");
    check_output("tick_nosat_const", 64'(sample_saturated), 64'h0);

    // Positive clamp, reported for one frame only.
    set_idle(); acc_op(1'b0, 32'h7FFF_FFF0); apply_stimulus("load_big");
    acc_op(1'b1, 32'h0000_0100); apply_stimulus("add_clamp");
    check_output("clamp_const", 64'(accumulator_out), 64'h7FFF_FFFF);
    set_idle(); sample_tick = 1'b1; apply_stimulus("tick_sat");
    check_output("tick_sat_const", 64'(sample_saturated), 64'h1);
    apply_stimulus("tick_clear");
    check_output("tick_clear_const", 64'(sample_saturated), 64'h0);

    // Tick sees the pre-write output channel value.
    set_idle();
    channel_write_addr = 4'd1; channel_write_val = 16'h0ABC; channel_write_enable = 1'b1;
    apply_stimulus("ch1_write");
    channel_write_val = 16'h0DEF; sample_tick = 1'b1;
    apply_stimulus("tick_prewrite");
    check_output("tick_prewrite_const", 64'(sample_out), 64'h0ABC);
    set_idle(); apply_stimulus("valid_drop");
    check_output("valid_drop_const", 64'(sample_out_valid), 64'h0);
    sample_tick = 1'b1; apply_stimulus("tick_new");
    check_output("tick_new_const", 64'(sample_out), 64'h0DEF);

    // Disabled cycle: writes and tick ignored, reads still served.
    set_idle();
    enable = 1'b0; sample_tick = 1'b1;
    channel_write_addr = 4'd5; channel_write_val = 16'hBEEF; channel_write_enable = 1'b1;
    acc_op(1'b0, 32'hDEAD_BEEF);
    read_addr[1] = 4'd5;
    apply_stimulus("disabled");
    check_output("disabled_valid_const", 64'(sample_out_valid), 64'h0);
    set_idle(); apply_stimulus("disabled_after");
    check_output("disabled_ch5_const", 64'(read_val[1]), 64'h0);

    // Randomized traffic, biased toward adds that clamp.
    for (int n = 0; n < 400; n++) begin
      enable                   = ($urandom_range(0, 7) != 0);
      sample_tick              = ($urandom_range(0, 3) == 0);
      channel_write_addr       = 4'($urandom_range(0, 15));
      channel_write_val        = 16'($urandom);
      channel_write_enable     = $urandom_range(0, 1) == 1;
      accumulator_write_val    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      accumulator_write_enable = $urandom_range(0, 1) == 1;
      accumulator_add_enable   = ($urandom_range(0, 3) != 0);
      read_addr[0]             = ($urandom_range(0, 2) == 0) ? channel_write_addr : 4'($urandom_range(0, 15));
      read_addr[1]             = ($urandom_range(0, 3) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
      apply_stimulus("random");
    end

    // Asynchronous reset in the middle of a cycle.
    set_idle();
    acc_op(1'b0, 32'h1357_2468);
    channel_write_addr = 4'd7; channel_write_val = 16'h5A5A; channel_write_enable = 1'b1;
    read_addr[0] = 4'd7; sample_tick = 1'b1;
    apply_stimulus("pre_reset");
    set_idle();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b1;
    read_addr[0] = 4'd7;
    apply_stimulus("post_reset");

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
